// File: rtl/sigmoid_share_arbiter_pkg.sv
// Shared constants, tag-width helper and the pipeline entry type for the
// sigmoid-sharing arbiter and its round-robin sub-arbiter.
package sigmoid_share_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_REQ  = 4;
    localparam int PERF_W     = 16;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                          valid;
        logic [tag_w(DEF_N_REQ)-1:0]   id;
        logic [DEF_DATA_W-1:0]         data;
    } pipe_entry_t;

endpackage

// File: rtl/sigmoid_share_arbiter_if.sv
// Request, shared-unit and response signals of the sigmoid-sharing arbiter.
interface sigmoid_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = sigmoid_share_pkg::tag_w(N_REQ)
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and valid/data hold until transfer.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_z;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       act_z;
    logic [DATA_W-1:0]       act_a;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_a;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_z, act_a, rsp_ready,
        input  req_ready, act_z, rsp_valid, rsp_id, rsp_a
    );

    modport slave (
        input  req_valid, req_z, act_a, rsp_ready,
        output req_ready, act_z, rsp_valid, rsp_id, rsp_a
    );

endinterface

// File: rtl/sigmoid_share_arbiter_rr.sv
// Round-robin grant over N requesters; the pointer advances past the winner.
import sigmoid_share_pkg::*;

module rr_arbiter_n #(
    parameter int N   = 4,
    parameter int IDW = tag_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] ptr_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] sel;
    int             idx;

    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            sel = IDW'(idx);
            if (en_i && !gnt_valid_o && req_i[sel]) begin
                gnt_valid_o = 1'b1;
                gnt_o[sel]  = 1'b1;
                gnt_id_o    = sel;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (int'(gnt_id_o) == N - 1) ? '0 : gnt_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Shares one combinational sigmoid unit among N_REQ requesters through a
// two-stage pipeline. Optional counters: SIGMOID_SHARE_ARBITER_PERF_EN.
import sigmoid_share_pkg::*;

module sigmoid_share_arbiter #(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = tag_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    sigmoid_share_arbiter_if.slave    bus,
`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
    output logic [N_REQ*PERF_W-1:0]   perf_grants,
    output logic [PERF_W-1:0]         perf_stall,
`endif
    output logic [ID_W-1:0]           dbg_rr_ptr_o,
    output logic                      dbg_s1_v_o,
    output logic                      dbg_s2_v_o
);

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             s1_q, s1_d, s2_q, s2_d;
    logic               s1_load, s2_load;
    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic [DATA_W-1:0]  gnt_z;

    assign s2_load = !s2_q.valid || bus.rsp_ready;
    assign s1_load = !s1_q.valid || s2_load;

    rr_arbiter_n #(.N(N_REQ), .IDW(ID_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (s1_load),
        .req_i       (bus.req_valid),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid),
        .ptr_o       (dbg_rr_ptr_o)
    );

    always_comb begin
        gnt_z = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_z = bus.req_z[i*DATA_W +: DATA_W];
        end
    end

    // An idle S1 keeps its old operand so the shared unit input does not toggle.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (s1_load) begin
            s1_d.valid = gnt_valid;
            if (gnt_valid) begin
                s1_d.id   = gnt_id;
                s1_d.data = gnt_z;
            end
        end
        if (s2_load) begin
            s2_d.valid = s1_q.valid;
            s2_d.id    = s1_q.id;
            s2_d.data  = bus.act_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.act_z     = s1_q.data;
    assign bus.rsp_valid = s2_q.valid;
    assign bus.rsp_id    = s2_q.id;
    assign bus.rsp_a     = s2_q.data;
    assign dbg_s1_v_o    = s1_q.valid;
    assign dbg_s2_v_o    = s2_q.valid;

`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
    logic [PERF_W-1:0] grant_cnt_q [N_REQ];
    logic [PERF_W-1:0] stall_cnt_q;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
            end
            if (s2_q.valid && !bus.rsp_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_perf
        assign perf_grants[i*PERF_W +: PERF_W] = grant_cnt_q[i];
    end
    assign perf_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Directed bench for sigmoid_share_arbiter; the sigmoid unit is a stub a = z ^ 8'h55.
module tb_sigmoid_share_arbiter;
  import sigmoid_share_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int EW = $bits(pipe_entry_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sigmoid_share_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) bus();
  assign bus.act_a = bus.act_z ^ 8'h55;

  logic [IW-1:0] dbg_rr_ptr;
  logic          dbg_s1_v, dbg_s2_v;
`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
  logic [N*PERF_W-1:0] perf_grants;
  logic [PERF_W-1:0]   perf_stall;
`endif

  sigmoid_share_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
    .perf_grants  (perf_grants),
    .perf_stall   (perf_stall),
`endif
    .dbg_rr_ptr_o (dbg_rr_ptr),
    .dbg_s1_v_o   (dbg_s1_v),
    .dbg_s2_v_o   (dbg_s2_v)
  );

  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] exp_q[$];
  int            grant_log[$];
  int            resp_cnt = 0;
  int            hs_cnt   = 0;
  logic [DW-1:0] rq[N][$];
  logic [N-1:0]  mon_hs;
  logic [N-1:0]  prev_v, prev_r;
  logic [DW-1:0] prev_z[N];
  logic          prev_rst = 1'b1;

  // ---------------- driver ----------------
  function automatic void drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (rq[i].size() > 0);
      bus.req_z[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endfunction

  // ---------------- scoreboard / protocol monitor ----------------
  task automatic monitor_sample();
    pipe_entry_t e;
    logic [EW-1:0] got;
    mon_hs = '0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        resp_cnt++;
        checks++;
        got = {1'b1, bus.rsp_id, bus.rsp_a};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got id=%0d a=%h, required no response", bus.rsp_id, bus.rsp_a);
        end else if (got !== exp_q[0]) begin
          fails++;
          $display("FAIL sb_order: got %h, required %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_hs[i] = 1'b1;
          hs_cnt++;
          grant_log.push_back(i);
          e.valid = 1'b1;
          e.id    = IW'(i);
          e.data  = bus.req_z[i*DW +: DW] ^ 8'h55;
          exp_q.push_back(e);
        end
      end
      checks++;
      if ($countones(bus.req_ready) > 1) begin
        fails++;
        $display("FAIL ready_onehot: got %b, required at most one bit", bus.req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (!prev_rst && prev_v[i] && !prev_r[i]) begin
          checks++;
          assert (bus.req_valid[i] && bus.req_z[i*DW +: DW] == prev_z[i]) else begin
            fails++;
            $display("FAIL req_protocol: requester %0d dropped or changed before handshake", i);
          end
        end
      end
    end
    prev_rst = rst;
    prev_v   = bus.req_valid;
    prev_r   = bus.req_ready;
    for (int i = 0; i < N; i++) prev_z[i] = bus.req_z[i*DW +: DW];
  endtask

  // One clock: sample at negedge, retire handshakes at posedge, drive at +2, return at +3.
  task automatic step();
    @(negedge clk);
    monitor_sample();
    @(posedge clk);
    for (int i = 0; i < N; i++) if (mon_hs[i]) void'(rq[i].pop_front());
    #2 drive_reqs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_reqs();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.rsp_ready = 1'b1;
    do_reset();
    rst = 1'b1;
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL rst_rsp_id: got %0d, required 0", bus.rsp_id); end
    checks++; if (bus.rsp_a !== 8'h00) begin fails++; $display("FAIL rst_rsp_a: got %h, required 00", bus.rsp_a); end
    checks++; if (bus.act_z !== 8'h00) begin fails++; $display("FAIL rst_act_z: got %h, required 00", bus.act_z); end
    checks++; if (dbg_rr_ptr !== 2'd0) begin fails++; $display("FAIL rst_rr_ptr: got %0d, required 0", dbg_rr_ptr); end
    checks++; if ({dbg_s1_v, dbg_s2_v} !== 2'b00) begin fails++; $display("FAIL rst_stage_v: got %b, required 00", {dbg_s1_v, dbg_s2_v}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    rq[1].push_back(8'h3A);
    drive_reqs();
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL single_ready: got %b, required 0010", bus.req_ready); end
    step();
    checks++; if (bus.act_z !== 8'h3A) begin fails++; $display("FAIL single_act_z: got %h, required 3a", bus.act_z); end
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b, required 0", bus.rsp_valid); end
    checks++; if (dbg_rr_ptr !== 2'd2) begin fails++; $display("FAIL single_ptr: got %0d, required 2", dbg_rr_ptr); end
    step();
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_a} !== {1'b1, 2'd1, 8'h6F}) begin
      fails++; $display("FAIL single_rsp: got v=%b id=%0d a=%h, required v=1 id=1 a=6f", bus.rsp_valid, bus.rsp_id, bus.rsp_a);
    end
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: got %b, required 0", bus.rsp_valid); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_rdy [6];
    logic [1:0] exp_ptr [6];
    logic       exp_rv  [6];
    logic [1:0] exp_id  [6];
    logic [7:0] exp_a   [6];
    exp_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    exp_ptr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    exp_rv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_id  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_a   = '{8'h00, 8'h55, 8'h45, 8'hD5, 8'h2A, 8'h00};
    do_reset();
    bus.rsp_ready = 1'b1;
    grant_log.delete();
    rq[0].push_back(8'h00); rq[1].push_back(8'h10); rq[2].push_back(8'h80); rq[3].push_back(8'h7F);
    drive_reqs();
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL all4_first_ready: got %b, required 0001", bus.req_ready); end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (bus.req_ready !== exp_rdy[k]) begin fails++; $display("FAIL all4_ready[%0d]: got %b, required %b", k, bus.req_ready, exp_rdy[k]); end
      checks++; if (dbg_rr_ptr !== exp_ptr[k]) begin fails++; $display("FAIL all4_ptr[%0d]: got %0d, required %0d", k, dbg_rr_ptr, exp_ptr[k]); end
      checks++; if (bus.rsp_valid !== exp_rv[k]) begin fails++; $display("FAIL all4_rv[%0d]: got %b, required %b", k, bus.rsp_valid, exp_rv[k]); end
      if (exp_rv[k]) begin
        checks++; if ({bus.rsp_id, bus.rsp_a} !== {exp_id[k], exp_a[k]}) begin
          fails++; $display("FAIL all4_rsp[%0d]: got id=%0d a=%h, required id=%0d a=%h", k, bus.rsp_id, bus.rsp_a, exp_id[k], exp_a[k]);
        end
      end
    end
    checks++; if (grant_log.size() != 4) begin fails++; $display("FAIL all4_grants: got %0d, required 4", grant_log.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (grant_log[k] != k) begin fails++; $display("FAIL all4_order[%0d]: got %0d, required %0d", k, grant_log[k], k); end
    end
  endtask

  task automatic test_backpressure();
    int r0, h0;
    bus.rsp_ready = 1'b0;
    grant_log.delete();
    r0 = resp_cnt; h0 = hs_cnt;
    rq[0].push_back(8'h11); rq[1].push_back(8'h22); rq[2].push_back(8'h33); rq[3].push_back(8'h44);
    drive_reqs();
    step();
    checks++; if (bus.act_z !== 8'h11 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_fill: got act_z=%h v=%b, required 11 0", bus.act_z, bus.rsp_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_a} !== {1'b1, 2'd0, 8'h44}) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d a=%h, required v=1 id=0 a=44", k, bus.rsp_valid, bus.rsp_id, bus.rsp_a);
      end
      checks++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b, required 0000", k, bus.req_ready); end
      checks++; if ({dbg_s1_v, dbg_s2_v} !== 2'b11 || bus.act_z !== 8'h22) begin
        fails++; $display("FAIL bp_inflight[%0d]: got s1s2=%b act_z=%h, required 11 22", k, {dbg_s1_v, dbg_s2_v}, bus.act_z);
      end
      if (k < 3) step();
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    checks++; if (resp_cnt - r0 != 4) begin fails++; $display("FAIL bp_resp_count: got %0d, required 4", resp_cnt - r0); end
    checks++; if (hs_cnt - h0 != 4) begin fails++; $display("FAIL bp_grant_count: got %0d, required 4", hs_cnt - h0); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); end
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      checks++; if (grant_log[k] != k) begin fails++; $display("FAIL bp_order[%0d]: got %0d, required %0d", k, grant_log[k], k); end
    end
  endtask

  task automatic test_fairness();
    int n;
    bus.rsp_ready = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 10; k++) begin
      rq[0].push_back(8'(k));
      rq[2].push_back(8'(8'h40 + k));
    end
    drive_reqs();
    n = 0;
    while (grant_log.size() < 20 && n < 60) begin
      step();
      n++;
    end
    checks++; if (n != 20) begin fails++; $display("FAIL fair_cycles: got %0d, required 20", n); end
    checks++; if (grant_log.size() != 20) begin fails++; $display("FAIL fair_grants: got %0d, required 20", grant_log.size()); end
    for (int k = 0; k < 20 && k < grant_log.size(); k++) begin
      checks++; if (grant_log[k] != ((k % 2 == 0) ? 0 : 2)) begin
        fails++; $display("FAIL fair_order[%0d]: got %0d, required %0d", k, grant_log[k], (k % 2 == 0) ? 0 : 2);
      end
    end
    for (int k = 0; k < 3; k++) step();
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL fair_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int r0;
    bus.rsp_ready = 1'b0;
    rq[1].push_back(8'hA1); rq[2].push_back(8'hB2); rq[3].push_back(8'hC3);
    drive_reqs();
    step();
    step();
    checks++; if ({dbg_s1_v, dbg_s2_v, bus.rsp_id, bus.act_z} !== {1'b1, 1'b1, 2'd3, 8'hA1}) begin
      fails++; $display("FAIL mid_setup: got s1=%b s2=%b id=%0d act_z=%h, required 1 1 3 a1", dbg_s1_v, dbg_s2_v, bus.rsp_id, bus.act_z);
    end
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_reqs();
    r0 = resp_cnt;
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %b, required 0", bus.rsp_valid); end
    checks++; if (dbg_rr_ptr !== 2'd0) begin fails++; $display("FAIL mid_ptr: got %0d, required 0", dbg_rr_ptr); end
    checks++; if ({dbg_s1_v, dbg_s2_v} !== 2'b00) begin fails++; $display("FAIL mid_stage_v: got %b, required 00", {dbg_s1_v, dbg_s2_v}); end
    checks++; if (bus.act_z !== 8'h00) begin fails++; $display("FAIL mid_act_z: got %h, required 00", bus.act_z); end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_ghost[%0d]: got %b, required 0", k, bus.rsp_valid); end
    end
    checks++; if (resp_cnt != r0) begin fails++; $display("FAIL mid_resp_count: got %0d, required %0d", resp_cnt, r0); end
  endtask

`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
  task automatic test_perf();
    int n;
    logic [15:0] g [4];
    do_reset();
    bus.rsp_ready = 1'b0;
    rq[1].push_back(8'h01);
    drive_reqs();
    for (int k = 0; k < 5; k++) step();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++; if (perf_stall !== 16'd3) begin fails++; $display("FAIL perf_stall_small: got %0d, required 3", perf_stall); end
    checks++; if (perf_grants[1*16 +: 16] !== 16'd1) begin fails++; $display("FAIL perf_g1_small: got %0d, required 1", perf_grants[1*16 +: 16]); end
    for (int k = 0; k < 70000; k++) rq[3].push_back(8'(k));
    rq[0].push_back(8'h05); rq[0].push_back(8'h06);
    drive_reqs();
    n = 0;
    while ((rq[3].size() > 0 || rq[0].size() > 0) && n < 80000) begin
      step();
      n++;
    end
    checks++; if (n >= 80000) begin fails++; $display("FAIL perf_timeout: got %0d cycles, required < 80000", n); end
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 4; i++) g[i] = perf_grants[i*16 +: 16];
    checks++; if (g[3] !== 16'hFFFF) begin fails++; $display("FAIL perf_g3_sat: got %h, required ffff", g[3]); end
    checks++; if (g[0] !== 16'd2) begin fails++; $display("FAIL perf_g0: got %0d, required 2", g[0]); end
    checks++; if (g[1] !== 16'd1) begin fails++; $display("FAIL perf_g1: got %0d, required 1", g[1]); end
    checks++; if (g[2] !== 16'd0) begin fails++; $display("FAIL perf_g2: got %0d, required 0", g[2]); end
    checks++; if (perf_stall !== 16'd3) begin fails++; $display("FAIL perf_stall: got %0d, required 3", perf_stall); end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_z     = '0;
    bus.rsp_ready = 1'b1;
    prev_v = '0;
    prev_r = '0;
    mon_hs = '0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid();
`ifdef SIGMOID_SHARE_ARBITER_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sigmoid_share_arbiter.md
Name: sigmoid_share_arbiter

Overview:
- Time-multiplexes one combinational sigmoid activation unit (4-bit LUT address plus 4-bit linear interpolation, 8-bit signed fixed point) among N requesters, e.g. the input, forget and output gates of an LSTM cell.
- Round-robin arbitration with valid/ready on the request side.
- Two-stage registered pipeline around the shared unit.
- Single tagged response bus with backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of z and activation values (signed fixed point).
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_z  in  N_REQ*DATA_W  packed z values; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- act_z  out  DATA_W  operand driven to the shared sigmoid unit's z input.
- act_a  in  DATA_W  result from the shared sigmoid unit (combinational from act_z).
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  index of the requester owning the response.
- rsp_a  out  DATA_W  activation value.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: rr_ptr=0, s1_v=0, s2_v=0, rsp_valid=0, rsp_id=0, rsp_a=0. act_z reflects s1_z, which resets to 0.
- Stage S1 registers: s1_v, s1_z, s1_id. act_z = s1_z.
- Stage S2 registers: s2_v, s2_a, s2_id. rsp_valid=s2_v, rsp_a=s2_a, rsp_id=s2_id.
- s2_load = !s2_v || rsp_ready.
- s1_load = !s1_v || s2_load.
- Arbitration (combinational):
  - Only when s1_load=1.
  - Search req_valid starting at index rr_ptr and wrapping modulo N_REQ.
  - The first valid index g gets req_ready[g]=1; at most one bit of req_ready is high.
  - When s1_load=0, req_ready=0.
- On a grant (rising edge): s1_v<=1, s1_z<=req_z[g], s1_id<=g, rr_ptr<=(g+1) mod N_REQ. rr_ptr wraps N_REQ-1 -> 0.
- If s1_load=1 and no request is valid: s1_v<=0 and rr_ptr is held.
- If s2_load=1: s2_v<=s1_v, s2_a<=act_a, s2_id<=s1_id.
- Stall: if s2_load=0, S2 holds and rsp_valid/rsp_id/rsp_a stay stable. S1 also holds when full, so the shared unit's input is stable.
- Latency: handshake at edge t makes the response visible after edge t+1 (rsp_valid high in cycle t+2). Throughput is 1 per cycle when rsp_ready=1.
- Ordering: responses leave in grant order; no reordering and no loss.
- Width rule: z and a pass through unmodified, with no sign extension or saturation. The DATA_W=8 split is 4-bit address plus 4-bit remainder, owned by the sigmoid unit.
- Requester rules: req_valid must not depend on req_ready. Once raised, req_valid/req_z hold until the handshake. Violations are a protocol error, flagged by a bench assertion.
- Simultaneous events: S2 draining, S1 advancing and a new grant all occur in the same cycle when rsp_ready=1.
- Reset mid-operation: both stages are invalidated and in-flight results are dropped with no response. rr_ptr returns to 0.

Optional Feature:
- Macro: SIGMOID_SHARE_ARBITER_PERF_EN.
- With the macro defined:
  - Adds output perf_grants [N_REQ*16]: per-requester 16-bit saturating grant counters (stick at 16'hFFFF).
  - Adds output perf_stall [16]: saturating count of cycles with s2_v=1 and rsp_ready=0.
  - All counters clear on rst.
- Without the macro: these ports and registers do not exist.

Decomposition:
- Package sigmoid_share_pkg:
  - DATA_W default constant.
  - Tag width function.
  - Typedef for the packed pipeline entry {valid, id, data}.
  - Perf counter width constant (16).
- Sub-module rr_arbiter_n: parameterised round-robin grant with pointer update, reused for other shared LUT units.

Test Plan:
Bench models the sigmoid unit as a stub act_a = act_z ^ 8'h55.
1. Single requester: req 1 only, z=8'h3A, rsp_ready=1 -> rsp_valid two cycles after handshake, rsp_id=1, rsp_a=8'h6F.
2. All four valid from reset: z=8'h00/8'h10/8'h80/8'h7F -> grants 0,1,2,3 in consecutive cycles, responses in that order, rr_ptr wraps to 0.
3. Backpressure: rsp_ready=0 for 3 cycles while 4 requests are pending -> rsp held stable, exactly 2 entries in flight, req_ready=0, no loss or duplication after release.
4. Fairness: req 0 and req 2 held continuously for 20 grants -> strict alternation 0,2,0,2, never more than 1 consecutive grant each.
5. Reset mid-operation: assert rst with S1 and S2 full -> next cycle rsp_valid=0, rr_ptr=0, dropped entries never appear.
6. PERF_EN build: 70000 grants to req 3 -> perf_grants[3] saturates at 16'hFFFF; other counters are correct.
